demux_1x4_reg: RTL

- Registered 1-to-4 demultiplexer; the inverse of the team's 4:1 select mux.
- One input stream is steered to one of four output slots by a 2-bit select, index = {s1,s0}.
- Each output has a one-entry holding register with a valid/ready handshake, so a stalled output does not block traffic already held in other slots.
- Sits between a single producer and four independent consumers in the dataflow library.

---
 rtl/demux_1x4_reg_pkg.sv | 15 +
 rtl/demux_1x4_reg_slot.sv | 51 +++++
 rtl/demux_1x4_reg.sv | 85 ++++++++
 3 files changed

// File: rtl/demux_1x4_reg_pkg.sv
// Shared constants and slot state type for the registered 1-to-4 demultiplexer.
// Optional build macro DEMUX_STATS_EN uses CNT_W/CNT_MAX for per-slot delivery counters.
package demux_1x4_reg_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_1x4_reg_slot.sv
// One output slot: a holding register with its valid bit and load/drain handling.
// With DEMUX_STATS_EN defined it also counts delivered beats, saturating at CNT_MAX.
//
// state      | meaning
// SLOT_EMPTY | nothing held, y keeps the last delivered value
// SLOT_FULL  | y holds a beat waiting for the consumer
module demux_1x4_reg_slot
  import demux_1x4_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
`ifdef DEMUX_STATS_EN
  output logic [CNT_W-1:0] cnt,
`endif
  output logic [WIDTH-1:0] y,
  output logic             valid
);

  slot_state_e state;

  // A load wins over a drain so a slot sustains one beat per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      y     <= '0;
    end else if (load) begin
      state <= SLOT_FULL;
      y     <= d;
    end else if (state == SLOT_FULL && ready) begin
      state <= SLOT_EMPTY;
    end
  end

  assign valid = (state == SLOT_FULL);

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (valid && ready && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer: select decode and input handshake over four slots.
// Build macro DEMUX_STATS_EN adds cnt0..cnt3 delivery counters and stall_any.
module demux_1x4_reg
  import demux_1x4_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
`ifdef DEMUX_STATS_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic             stall_any,
`endif
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3
);

  logic [SEL_W-1:0]   sel;
  logic [NUM_OUT-1:0] v;
  logic [NUM_OUT-1:0] r;
  logic [NUM_OUT-1:0] load;
  logic [WIDTH-1:0]   y [NUM_OUT];
`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0]   cnt [NUM_OUT];
`endif

  assign sel = {s1, s0};
  assign r   = {r3, r2, r1, r0};

  // Only the selected slot gates acceptance; other slots never block.
  assign in_ready = ~rst & (~v[sel] | r[sel]);

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
    assign load[gi] = in_valid & in_ready & (sel == SEL_W'(gi));

    demux_1x4_reg_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[gi]),
      .d     (d),
      .ready (r[gi]),
`ifdef DEMUX_STATS_EN
      .cnt   (cnt[gi]),
`endif
      .y     (y[gi]),
      .valid (v[gi])
    );
  end

  assign y0 = y[0];
  assign y1 = y[1];
  assign y2 = y[2];
  assign y3 = y[3];
  assign v0 = v[0];
  assign v1 = v[1];
  assign v2 = v[2];
  assign v3 = v[3];

`ifdef DEMUX_STATS_EN
  assign cnt0      = cnt[0];
  assign cnt1      = cnt[1];
  assign cnt2      = cnt[2];
  assign cnt3      = cnt[3];
  assign stall_any = |(v & ~r);
`endif

endmodule
